// File: rtl/tsb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tsb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } tsb_state_t;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_MAX_TENURE = 8;
  localparam int unsigned DEF_TURNAROUND = 1;

  // Bits needed to hold a counter that reaches max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  // Bits needed to index n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Requester/enable bundle between requester logic, arbiter and tri-state cells.
interface tristate_bus_arbiter_if
  import tsb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
);
  localparam int unsigned IDW = idx_width(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] enableN;
  logic [IDW-1:0]  grant_id;
  logic            bus_busy;
  logic            tenure_exp;

  modport master (
    input  req,
    output enableN,
    output grant_id,
    output bus_busy,
    output tenure_exp
  );

  modport slave (
    output req,
    input  enableN,
    input  grant_id,
    input  bus_busy,
    input  tenure_exp
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_priority_picker
  import tsb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;

  // Rotate so ptr lands at bit 0, find lowest set bit, then unrotate modulo NREQ.
  always_comb begin
    dbl   = {req, req};
    rot   = NREQ'(dbl >> ptr);
    valid = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IDW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    idx = sum[IDW-1:0];
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state line with bounded tenure
// and a forced all-high-Z turnaround gap between owners.
module tristate_bus_arbiter
  import tsb_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned MAX_TENURE = DEF_MAX_TENURE,
  parameter int unsigned TURNAROUND = DEF_TURNAROUND
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tristate_bus_arbiter_if.master bus
);

  localparam int unsigned IDW    = idx_width(NREQ);
  localparam int unsigned CNT_W  = cnt_width(MAX_TENURE);
  localparam int unsigned GCNT_W = cnt_width(TURNAROUND);

  tsb_state_t        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [GCNT_W-1:0] gcnt_q,       gcnt_d;
  logic [IDW-1:0]    rr_ptr_q,     rr_ptr_d;
  logic [NREQ-1:0]   enable_n_q,   enable_n_d;
  logic [IDW-1:0]    grant_id_q,   grant_id_d;
  logic              bus_busy_q,   bus_busy_d;
  logic              tenure_exp_q, tenure_exp_d;

  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;
  logic              owner_req;
  logic              arbitrate;

  rr_priority_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = bus.req[grant_id_q];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    rr_ptr_d     = rr_ptr_q;
    enable_n_d   = enable_n_q;
    grant_id_d   = grant_id_q;
    bus_busy_d   = bus_busy_q;
    tenure_exp_d = 1'b0;
    arbitrate    = 1'b0;

    case (state_q)
      IDLE: arbitrate = 1'b1;
      GRANT: begin
        if (owner_req && (cnt_q < CNT_W'(MAX_TENURE))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d      = GAP;
          enable_n_d   = '1;
          bus_busy_d   = 1'b0;
          tenure_exp_d = owner_req;
          rr_ptr_d     = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
          gcnt_d       = GCNT_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q >= GCNT_W'(TURNAROUND)) begin
          arbitrate = 1'b1;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared arbitration step for IDLE and the last GAP cycle.
    if (arbitrate) begin
      if (pick_valid) begin
        state_d    = GRANT;
        enable_n_d = ~(NREQ'(1) << pick_idx);
        grant_id_d = pick_idx;
        bus_busy_d = 1'b1;
        cnt_d      = CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Async reset drops every enable immediately, without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      rr_ptr_q     <= '0;
      enable_n_q   <= '1;
      grant_id_q   <= '0;
      bus_busy_q   <= 1'b0;
      tenure_exp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      rr_ptr_q     <= rr_ptr_d;
      enable_n_q   <= enable_n_d;
      grant_id_q   <= grant_id_d;
      bus_busy_q   <= bus_busy_d;
      tenure_exp_q <= tenure_exp_d;
    end
  end

  assign bus.enableN    = enable_n_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.bus_busy   = bus_busy_q;
  assign bus.tenure_exp = tenure_exp_q;

endmodule
